// File: rtl/i2c_write_arbiter.sv
// Round-robin arbiter sharing one I2C write engine among NREQ requesters:
// picks a winner, launches the engine, watches its ready handshake, reports done/err.
module i2c_write_arbiter #(
    parameter int NREQ      = 4,
    parameter int ADDR_SZ   = 7,
    parameter int WORD_SZ   = 8,
    parameter int PTR_SZ    = 3,
    parameter int START_LIM = 8,
    parameter int TIMEOUT   = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*ADDR_SZ-1:0]   req_addr,
    input  logic [NREQ*PTR_SZ-1:0]    req_ptr_begin,
    input  logic [NREQ*PTR_SZ-1:0]    req_ptr_end,
    input  logic [NREQ*WORD_SZ-1:0]   req_data,
    output logic [NREQ-1:0]           grant,
    output logic [NREQ-1:0]           done,
    output logic [NREQ-1:0]           err,
    output logic [PTR_SZ-1:0]         cur_ptr,
    output logic                      busy,
    output logic                      eng_init,
    output logic [ADDR_SZ-1:0]        eng_addr,
    output logic [PTR_SZ-1:0]         eng_ptr_begin,
    output logic [PTR_SZ-1:0]         eng_ptr_end,
    output logic [WORD_SZ-1:0]        eng_data,
    input  logic [PTR_SZ-1:0]         eng_ptr_cur,
    input  logic                      eng_ready
);

    localparam int          IDX_W  = $clog2(NREQ);
    localparam int          CNT_W  = $clog2(TIMEOUT) + 1;
    localparam int unsigned NREQ_U = NREQ;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] START_END = CNT_W'(START_LIM - 1);
    localparam logic [CNT_W-1:0] XFER_END  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_START_WAIT,
        S_XFER,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [NREQ-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [ADDR_SZ-1:0] addr_q, addr_d;
    logic [PTR_SZ-1:0]  pb_q, pb_d;
    logic [PTR_SZ-1:0]  pe_q, pe_d;

    logic [IDX_W-1:0]   hi_idx, lo_idx, win_idx;
    logic               hi_found, lo_found, win_found;
    logic [CNT_W-1:0]   cnt_inc;

    // Round robin: first requester above last wins; otherwise wrap to the lowest one.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int unsigned i = 0; i < NREQ_U; i++) begin
            if (req[i] && !lo_found) begin
                lo_idx   = IDX_W'(i);
                lo_found = 1'b1;
            end
            if (req[i] && !hi_found && (i > 32'(last_q))) begin
                hi_idx   = IDX_W'(i);
                hi_found = 1'b1;
            end
        end
        win_found = lo_found;
        win_idx   = hi_found ? hi_idx : lo_idx;
    end

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        addr_d  = addr_q;
        pb_d    = pb_q;
        pe_d    = pe_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    idx_d            = win_idx;
                    addr_d           = req_addr[win_idx*ADDR_SZ +: ADDR_SZ];
                    pb_d             = req_ptr_begin[win_idx*PTR_SZ +: PTR_SZ];
                    pe_d             = req_ptr_end[win_idx*PTR_SZ +: PTR_SZ];
                    state_d          = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_START_WAIT;
            end
            S_START_WAIT: begin
                if (!eng_ready) begin
                    cnt_d   = '0;
                    state_d = S_XFER;
                end else if (cnt_q == START_END) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_XFER: begin
                if (eng_ready) begin
                    state_d = S_DONE;
                end else if (cnt_q == XFER_END) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DONE: begin
                last_d  = idx_q;
                grant_d = '0;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            last_q  <= IDX_W'(NREQ - 1);
            cnt_q   <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            pb_q    <= '0;
            pe_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            pb_q    <= pb_d;
            pe_q    <= pe_d;
        end
    end

    assign grant         = grant_q;
    assign busy          = (state_q != S_IDLE);
    assign eng_init      = (state_q == S_LAUNCH);
    assign done          = (state_q == S_DONE) ? grant_q : '0;
    assign err           = ((state_q == S_DONE) && err_q) ? grant_q : '0;
    assign eng_addr      = addr_q;
    assign eng_ptr_begin = pb_q;
    assign eng_ptr_end   = pe_q;
    assign cur_ptr       = eng_ptr_cur;
    assign eng_data      = (grant_q != '0) ? req_data[idx_q*WORD_SZ +: WORD_SZ] : '0;

endmodule

// File: tb/tb_i2c_write_arbiter.sv
// Bench for i2c_write_arbiter: timestamp-level model of each transaction checked every
// cycle, plus directed scenarios with hand-computed grants and latencies.
module tb_i2c_write_arbiter;

    localparam int NREQ      = 4;
    localparam int ADDR_SZ   = 7;
    localparam int WORD_SZ   = 8;
    localparam int PTR_SZ    = 3;
    localparam int START_LIM = 8;
    localparam int TIMEOUT   = 1024;
    localparam int NEVER     = 1_000_000;

    logic                     clk   = 1'b0;
    logic                     reset = 1'b1;
    logic [NREQ-1:0]          req   = '0;
    logic [NREQ*ADDR_SZ-1:0]  req_addr;
    logic [NREQ*PTR_SZ-1:0]   req_ptr_begin;
    logic [NREQ*PTR_SZ-1:0]   req_ptr_end;
    logic [NREQ*WORD_SZ-1:0]  req_data;
    logic [NREQ-1:0]          grant, done, err;
    logic [PTR_SZ-1:0]        cur_ptr, eng_ptr_begin, eng_ptr_end;
    logic [PTR_SZ-1:0]        eng_ptr_cur = '0;
    logic                     busy, eng_init;
    logic                     eng_ready = 1'b1;
    logic [ADDR_SZ-1:0]       eng_addr;
    logic [WORD_SZ-1:0]       eng_data;

    logic [ADDR_SZ-1:0] addr_tab [NREQ] = '{7'h3C, 7'h21, 7'h50, 7'h7F};
    logic [PTR_SZ-1:0]  pb_tab   [NREQ] = '{3'd0, 3'd1, 3'd5, 3'd0};
    logic [PTR_SZ-1:0]  pe_tab   [NREQ] = '{3'd2, 3'd4, 3'd3, 3'd7};

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    // engine behaviour for the next launch: ready drops cfg_d cycles after init, stays low cfg_w cycles
    int cfg_d = 2;
    int cfg_w = 40;
    int eng_l = -10_000_000;
    int eng_d = 0;
    int eng_w = 0;

    function automatic logic [WORD_SZ-1:0] word_of(input int i, input logic [PTR_SZ-1:0] p);
        return WORD_SZ'(((i + 1) << 4) | int'(p));
    endfunction

    for (genvar g = 0; g < NREQ; g++) begin : g_req
        assign req_addr[g*ADDR_SZ +: ADDR_SZ]    = addr_tab[g];
        assign req_ptr_begin[g*PTR_SZ +: PTR_SZ] = pb_tab[g];
        assign req_ptr_end[g*PTR_SZ +: PTR_SZ]   = pe_tab[g];
        assign req_data[g*WORD_SZ +: WORD_SZ]    = word_of(g, eng_ptr_cur);
    end

    i2c_write_arbiter #(
        .NREQ(NREQ), .ADDR_SZ(ADDR_SZ), .WORD_SZ(WORD_SZ), .PTR_SZ(PTR_SZ),
        .START_LIM(START_LIM), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr),
        .req_ptr_begin(req_ptr_begin), .req_ptr_end(req_ptr_end), .req_data(req_data),
        .grant(grant), .done(done), .err(err), .cur_ptr(cur_ptr), .busy(busy),
        .eng_init(eng_init), .eng_addr(eng_addr), .eng_ptr_begin(eng_ptr_begin),
        .eng_ptr_end(eng_ptr_end), .eng_data(eng_data), .eng_ptr_cur(eng_ptr_cur),
        .eng_ready(eng_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        eng_ready   = !((cyc >= eng_l + eng_d) && (cyc < eng_l + eng_d + eng_w));
        eng_ptr_cur = PTR_SZ'(cyc);
    end

    always @(negedge clk) begin
        if (reset) begin
            eng_l = -10_000_000;
        end else if (eng_init === 1'b1) begin
            eng_l = cyc;
            eng_d = cfg_d;
            eng_w = cfg_w;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Transaction model: launch cycle, done cycle and error computed from the engine timing.
    logic              m_valid  = 1'b0;
    logic              m_active = 1'b0;
    logic              m_err    = 1'b0;
    int                m_w      = 0;
    int                m_l      = 0;
    int                m_dn     = 0;
    int                m_last   = NREQ - 1;
    logic [ADDR_SZ-1:0] m_addr  = '0;
    logic [PTR_SZ-1:0]  m_pb    = '0;
    logic [PTR_SZ-1:0]  m_pe    = '0;

    int              init_cyc   = 0;
    int              done_cyc   = 0;
    int              done_count = 0;
    logic [NREQ-1:0] done_val   = '0;
    logic [NREQ-1:0] err_val    = '0;
    logic [NREQ-1:0] grant_log [$];

    always @(negedge clk) begin
        logic [NREQ-1:0] e_grant;
        int x;
        int r;
        if (m_valid) begin
            e_grant = m_active ? (NREQ'(1) << m_w) : '0;
            chk("grant", grant, e_grant);
            chk("busy", busy, m_active);
            chk("eng_init", eng_init, m_active && (cyc == m_l));
            chk("done", done, (m_active && cyc == m_dn) ? e_grant : '0);
            chk("err", err, (m_active && cyc == m_dn && m_err) ? e_grant : '0);
            chk("eng_addr", eng_addr, m_addr);
            chk("eng_ptr_begin", eng_ptr_begin, m_pb);
            chk("eng_ptr_end", eng_ptr_end, m_pe);
            chk("cur_ptr", cur_ptr, eng_ptr_cur);
            chk("eng_data", eng_data, m_active ? word_of(m_w, eng_ptr_cur) : '0);
            if (eng_init === 1'b1) begin
                init_cyc = cyc;
                grant_log.push_back(grant);
            end
            if (done !== '0) begin
                done_cyc = cyc;
                done_val = done;
                err_val  = err;
                done_count++;
            end
        end
        if (reset) begin
            m_valid  = 1'b1;
            m_active = 1'b0;
            m_err    = 1'b0;
            m_last   = NREQ - 1;
            m_addr   = '0;
            m_pb     = '0;
            m_pe     = '0;
        end else if (m_active) begin
            if (cyc == m_dn) begin
                m_last   = m_w;
                m_active = 1'b0;
            end
        end else if (req != '0) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (req[(m_last + k) % NREQ]) begin
                    m_w = (m_last + k) % NREQ;
                    break;
                end
            end
            m_active = 1'b1;
            m_l      = cyc + 1;
            m_addr   = addr_tab[m_w];
            m_pb     = pb_tab[m_w];
            m_pe     = pe_tab[m_w];
            if (cfg_d > START_LIM) begin
                m_dn  = m_l + START_LIM + 1;
                m_err = 1'b1;
            end else begin
                x = m_l + cfg_d + 1;
                r = m_l + cfg_d + cfg_w;
                if (r <= x + TIMEOUT - 1) begin
                    m_dn  = r + 1;
                    m_err = 1'b0;
                end else begin
                    m_dn  = x + TIMEOUT;
                    m_err = 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_req(input logic [NREQ-1:0] r);
        req = r;
        step();
        req = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        int start;
        int k;
        start = done_count;
        k = 0;
        while (done_count == start && k < limit) begin
            step();
            k++;
        end
        chk({name, "_done_seen"}, done_count - start, 1);
    endtask

    initial begin
        int n;
        int dc0;
        int gl0;

        repeat (3) step();
        reset = 1'b0;
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_eng_addr", eng_addr, 0);

        // single request: ready drops 2 cycles after init, rises 40 later
        cfg_d = 2;
        cfg_w = 40;
        step();
        req = 4'b0001;
        n = cyc;
        step();
        req = '0;
        chk("t1_init_now", eng_init, 1);
        chk("t1_grant_now", grant, 4'b0001);
        chk("t1_busy_now", busy, 1);
        chk("t1_addr", eng_addr, 7'h3C);
        wait_done("t1", 200);
        chk("t1_init_cyc", init_cyc, n + 1);
        chk("t1_latency", done_cyc - init_cyc, 43);
        chk("t1_done", done_val, 4'b0001);
        chk("t1_err", err_val, 4'b0000);

        // simultaneous requests held high from a fresh reset
        do_reset();
        cfg_d = 1;
        cfg_w = 3;
        gl0 = grant_log.size();
        dc0 = done_count;
        req = 4'b1011;
        for (int k = 0; k < 200 && grant_log.size() < gl0 + 4; k++) step();
        req = '0;
        for (int k = 0; k < 50 && done_count < dc0 + 4; k++) step();
        chk("t2_grant_count", grant_log.size() - gl0, 4);
        if (grant_log.size() >= gl0 + 4) begin
            chk("t2_g0", grant_log[gl0],     4'b0001);
            chk("t2_g1", grant_log[gl0 + 1], 4'b0010);
            chk("t2_g2", grant_log[gl0 + 2], 4'b1000);
            chk("t2_g3", grant_log[gl0 + 3], 4'b0001);
        end
        chk("t2_dones", done_count - dc0, 4);
        repeat (4) step();
        chk("t2_no_extra", grant_log.size() - gl0, 4);

        // rotation: serve requester 2 (begin > end window), then 0101 searches 3 then 0
        pulse_req(4'b0100);
        chk("t3_grant2", grant, 4'b0100);
        chk("t3_pb", eng_ptr_begin, 5);
        chk("t3_pe", eng_ptr_end, 3);
        wait_done("t3a", 100);
        chk("t3a_err", err_val, 0);
        pulse_req(4'b0101);
        chk("t3_wrap_grant", grant, 4'b0001);
        wait_done("t3b", 100);

        // start timeout: ready never drops
        cfg_d = NEVER;
        pulse_req(4'b0010);
        wait_done("t4", 100);
        chk("t4_latency", done_cyc - init_cyc, START_LIM + 1);
        chk("t4_done", done_val, 4'b0010);
        chk("t4_err", err_val, 4'b0010);

        // transfer timeout: ready drops and stays low
        cfg_d = 2;
        cfg_w = NEVER;
        pulse_req(4'b1000);
        wait_done("t5", TIMEOUT + 100);
        chk("t5_latency", done_cyc - init_cyc, TIMEOUT + 3);
        chk("t5_err", err_val, 4'b1000);
        chk("t5_idle", busy, 0);
        do_reset();

        // reset mid-XFER
        cfg_d = 2;
        cfg_w = 30;
        pulse_req(4'b0010);
        chk("t6_first_grant", grant, 4'b0010);
        wait_done("t6a", 100);
        pulse_req(4'b0100);
        repeat (15) step();
        chk("t6_in_xfer", busy, 1);
        dc0 = done_count;
        do_reset();
        chk("t6_rst_grant", grant, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_addr", eng_addr, 0);
        chk("t6_rst_pb", eng_ptr_begin, 0);
        repeat (40) step();
        chk("t6_no_done", done_count - dc0, 0);
        pulse_req(4'b0111);
        chk("t6_after_rst_grant", grant, 4'b0001);
        wait_done("t6b", 100);

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
